// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the RV32I decode stage.
// The decode stage uses the master view; the fetch/execute environment uses the slave view.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;

    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_val;
    logic [XLEN-1:0] ex_rs2_val;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rs1_addr;
    logic [4:0]      ex_rs2_addr;
    logic [4:0]      ex_rd_addr;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic            ex_illegal;

    modport master (
        input  if_valid, if_instr, if_pc, ex_ready,
        output if_ready, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
               ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_opcode, ex_funct3,
               ex_funct7, ex_illegal
    );

    modport slave (
        output if_valid, if_instr, if_pc, ex_ready,
        input  if_ready, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
               ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_opcode, ex_funct3,
               ex_funct7, ex_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage with ID/EX register: operand capture with writeback bypass,
// immediate generation, illegal-opcode flagging and a one-cycle load-use bubble.
module decode_stage #(
    parameter int XLEN      = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    decode_stage_if.master  bus,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_rd_data,
    input  logic            wb_wr_enable,
    input  logic            flush
);
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // ID/EX register
    logic                  out_valid_reg;
    logic                  dep_hold_reg;
    logic [XLEN-1:0]       pc_reg;
    logic [XLEN-1:0]       imm_reg;
    logic [1:0][4:0]       rs_addr_reg;
    logic [1:0][XLEN-1:0]  rs_val_reg;
    logic [4:0]            rd_reg;
    logic [6:0]            opcode_reg;
    logic [2:0]            funct3_reg;
    logic [6:0]            funct7_reg;
    logic                  illegal_reg;

    logic                  out_valid_next;
    logic                  dep_hold_next;
    logic [1:0][XLEN-1:0]  rs_val_next;

    // Decode of the offered instruction
    logic [31:0]           instr;
    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [1:0][4:0]       rs_addr_in;
    logic [1:0][XLEN-1:0]  rs_data_in;
    logic [1:0]            rs_used;
    logic signed [31:0]    imm32;
    logic [XLEN-1:0]       imm_ext;
    logic                  illegal;

    logic                  ex_valid_int;
    logic                  if_ready_int;
    logic                  fire;
    logic                  accept;
    logic                  held;
    logic                  hazard;

    assign instr         = bus.if_instr;
    assign opcode        = instr[6:0];
    assign rd            = instr[11:7];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign rs_addr_in[0] = instr[19:15];
    assign rs_addr_in[1] = instr[24:20];
    assign rs_data_in[0] = rs1_data;
    assign rs_data_in[1] = rs2_data;

    assign rs1_addr = rs_addr_in[0];
    assign rs2_addr = rs_addr_in[1];

    always_comb begin
        imm32 = '0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:                 imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:                imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                               instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm32 = {instr[31:12], 12'h000};
            OP_JAL:                   imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                               instr[20], instr[30:21], 1'b0};
            default:                  imm32 = '0;
        endcase
    end

    assign imm_ext = XLEN'(imm32);

    always_comb begin
        illegal = 1'b1;
        case (opcode)
            OP_LOAD, OP_FENCE, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: illegal = 1'b0;
            default:                                       illegal = 1'b1;
        endcase
    end

    // Upper-immediate and JAL forms carry no rs1 field; only R/S/B read rs2.
    assign rs_used[0] = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign rs_used[1] = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);

    assign ex_valid_int = out_valid_reg & ~dep_hold_reg;
    assign if_ready_int = ~out_valid_reg | (bus.ex_ready & ~dep_hold_reg);
    assign fire         = ex_valid_int & bus.ex_ready;
    assign accept       = bus.if_valid & if_ready_int & ~flush;
    assign held         = out_valid_reg & ~fire;

    // Consumer accepted while its producing load leaves: execute cannot have the data yet.
    assign hazard = fire && accept && opcode_reg == OP_LOAD && rd_reg != 5'd0 &&
                    ((rs_used[0] && rs_addr_in[0] == rd_reg) ||
                     (rs_used[1] && rs_addr_in[1] == rd_reg));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic            src_hit;
            logic            held_hit;
            logic [XLEN-1:0] cap_val;

            assign src_hit  = BYPASS_EN && wb_wr_enable && wb_rd_addr != 5'd0 &&
                              wb_rd_addr == rs_addr_in[gi];
            assign held_hit = BYPASS_EN && wb_wr_enable && wb_rd_addr != 5'd0 &&
                              wb_rd_addr == rs_addr_reg[gi];
            assign cap_val  = (rs_addr_in[gi] == 5'd0) ? '0 :
                              src_hit                  ? wb_rd_data : rs_data_in[gi];

            // A held operand tracks writeback so it is current when execute finally takes it.
            assign rs_val_next[gi] = flush                ? rs_val_reg[gi] :
                                     accept               ? cap_val :
                                     (held && held_hit)   ? wb_rd_data : rs_val_reg[gi];
        end
    endgenerate

    always_comb begin
        out_valid_next = out_valid_reg;
        dep_hold_next  = 1'b0;
        if (flush) begin
            out_valid_next = 1'b0;
        end else if (accept) begin
            out_valid_next = 1'b1;
            dep_hold_next  = hazard;
        end else if (fire) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            dep_hold_reg  <= 1'b0;
            pc_reg        <= '0;
            imm_reg       <= '0;
            rs_addr_reg   <= '0;
            rs_val_reg    <= '0;
            rd_reg        <= '0;
            opcode_reg    <= '0;
            funct3_reg    <= '0;
            funct7_reg    <= '0;
            illegal_reg   <= 1'b0;
        end else begin
            out_valid_reg <= out_valid_next;
            dep_hold_reg  <= dep_hold_next;
            rs_val_reg    <= rs_val_next;
            if (accept) begin
                pc_reg      <= bus.if_pc;
                imm_reg     <= imm_ext;
                rs_addr_reg <= rs_addr_in;
                rd_reg      <= rd;
                opcode_reg  <= opcode;
                funct3_reg  <= funct3;
                funct7_reg  <= funct7;
                illegal_reg <= illegal;
            end
        end
    end

    assign bus.if_ready    = if_ready_int;
    assign bus.ex_valid    = ex_valid_int;
    assign bus.ex_pc       = pc_reg;
    assign bus.ex_rs1_val  = rs_val_reg[0];
    assign bus.ex_rs2_val  = rs_val_reg[1];
    assign bus.ex_imm      = imm_reg;
    assign bus.ex_rs1_addr = rs_addr_reg[0];
    assign bus.ex_rs2_addr = rs_addr_reg[1];
    assign bus.ex_rd_addr  = rd_reg;
    assign bus.ex_opcode   = opcode_reg;
    assign bus.ex_funct3   = funct3_reg;
    assign bus.ex_funct7   = funct7_reg;
    assign bus.ex_illegal  = illegal_reg;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: the bench acts as register file, a scoreboard queue holds accepted
// instructions and a monitor checks each delivery against architectural register values.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  wb_rd_addr = '0;
    logic [31:0] wb_rd_data = '0;
    logic        wb_wr_enable = 1'b0;
    logic        flush = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] regs [32];
    logic [31:0] pc_cnt = 32'h0000_1000;

    decode_stage_if #(.XLEN(32)) bus();

    decode_stage #(.XLEN(32), .BYPASS_EN(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .wb_rd_addr   (wb_rd_addr),
        .wb_rd_data   (wb_rd_data),
        .wb_wr_enable (wb_wr_enable),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    // Register file model: combinational read, x0 hard-wired to zero.
    always @(posedge clk)
        if (wb_wr_enable && wb_rd_addr != 5'd0) regs[wb_rd_addr] <= wb_rd_data;

    function automatic logic [31:0] reg_val(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : regs[a];
    endfunction

    assign rs1_data = reg_val(rs1_addr);
    assign rs2_data = reg_val(rs2_addr);

    // Immediate as the ISA defines it: signed field values, branch/jump offsets in halfword units.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int v;
        case (w[6:0])
            7'h03, 7'h13, 7'h67: v = int'($signed(w[31:20]));
            7'h23:               v = int'($signed({w[31:25], w[11:7]}));
            7'h63:               v = 2 * int'($signed({w[31], w[7], w[30:25], w[11:8]}));
            7'h37, 7'h17:        v = int'(w[31:12]) * 4096;
            7'h6F:               v = 2 * int'($signed({w[31], w[19:12], w[20], w[30:21]}));
            default:             v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic ref_illegal(input logic [6:0] op);
        return !(op inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                            7'h63, 7'h67, 7'h6F, 7'h0F, 7'h73});
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [14];
        logic [31:0] w;
        ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63,
                7'h67, 7'h6F, 7'h0F, 7'h73, 7'h03, 7'h7F, 7'h0B};
        w        = $urandom;
        w[6:0]   = ops[$urandom_range(0, 13)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every delivery must match the oldest outstanding instruction.
    always @(negedge clk) begin
        if (!reset && bus.ex_valid && bus.ex_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery got pc %h expected none", bus.ex_pc);
            end else begin
                mon_e = sb_q.pop_front();
                $display("TXN pc=%h instr=%h rs1=%h rs2=%h imm=%h", mon_e.pc, mon_e.instr,
                         bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_imm);
                chk("pc",       bus.ex_pc,          mon_e.pc);
                chk("opcode",   32'(bus.ex_opcode),  32'(mon_e.instr[6:0]));
                chk("funct3",   32'(bus.ex_funct3),  32'(mon_e.instr[14:12]));
                chk("funct7",   32'(bus.ex_funct7),  32'(mon_e.instr[31:25]));
                chk("rd",       32'(bus.ex_rd_addr), 32'(mon_e.instr[11:7]));
                chk("rs1_addr", 32'(bus.ex_rs1_addr), 32'(mon_e.instr[19:15]));
                chk("rs2_addr", 32'(bus.ex_rs2_addr), 32'(mon_e.instr[24:20]));
                chk("imm",      bus.ex_imm,         ref_imm(mon_e.instr));
                chk("illegal",  32'(bus.ex_illegal), 32'(ref_illegal(mon_e.instr[6:0])));
                chk("rs1_val",  bus.ex_rs1_val,     reg_val(mon_e.instr[19:15]));
                chk("rs2_val",  bus.ex_rs2_val,     reg_val(mon_e.instr[24:20]));
            end
        end
    end

    // One clock cycle of stimulus, entered and left 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic fl, input logic er,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       output logic rdy, output logic evl);
        exp_t e;
        bus.if_valid = v;
        bus.if_instr = ins;
        bus.if_pc    = pc_cnt;
        bus.ex_ready = er;
        flush        = fl;
        wb_wr_enable = we;
        wb_rd_addr   = wa;
        wb_rd_data   = wd;
        @(negedge clk);
        rdy = bus.if_ready;
        evl = bus.ex_valid;
        if (v && ($urandom_range(0, 15) == 0)) chk("rs1_addr_comb", 32'(rs1_addr), 32'(ins[19:15]));
        if (fl) sb_q.delete();
        if (v && rdy && !fl) begin
            e.instr = ins;
            e.pc    = pc_cnt;
            sb_q.push_back(e);
        end
        if (v) pc_cnt = pc_cnt + 32'd4;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic er, output logic rdy, output logic evl);
        cyc(1'b0, 32'd0, 1'b0, er, 1'b0, 5'd0, 32'd0, rdy, evl);
    endtask

    task automatic drain();
        logic r, e;
        int   n;
        n = 0;
        while ((sb_q.size() != 0 || bus.ex_valid) && n < 10) begin
            idle(1'b1, r, e);
            n++;
        end
        checks++;
        if (sb_q.size() != 0 || bus.ex_valid) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r, e, fl;
        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.if_pc    = '0;
        bus.ex_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("reset_if_ready", 32'(bus.if_ready), 32'd1);
        chk("reset_ex_pc",    bus.ex_pc,         32'd0);
        chk("reset_ex_imm",   bus.ex_imm,        32'd0);
        chk("reset_ex_rs1",   bus.ex_rs1_val,    32'd0);
        chk("reset_ex_op",    32'(bus.ex_opcode), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 1; i < 32; i++)
            cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'(i), $urandom, r, e);

        // ADDI x1,x0,-5
        cyc(1'b1, 32'hFFB00093, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, r, e);
        chk("addi_valid", 32'(bus.ex_valid),  32'd1);
        chk("addi_imm",   bus.ex_imm,         32'hFFFF_FFFB);
        chk("addi_rd",    32'(bus.ex_rd_addr), 32'd1);
        drain();

        // ADD x3,x1,x2 with writeback of x1 in the same cycle
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h5555, r, e);
        cyc(1'b1, 32'h002081B3, 1'b0, 1'b1, 1'b1, 5'd1, 32'h1234, r, e);
        chk("bypass_rs1", bus.ex_rs1_val, 32'h1234);
        drain();

        // Held instruction picks up a later writeback; fetch is stalled meanwhile
        cyc(1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, r, e);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 32'hFFB00093, 1'b0, 1'b0, (k == 1), 5'd2, 32'hAA, r, e);
            chk("hold_if_ready", 32'(r), 32'd0);
        end
        chk("hold_rs2", bus.ex_rs2_val, 32'hAA);
        drain();

        // LW x5,0(x1) then ADD x6,x5,x5: exactly one bubble
        cyc(1'b1, 32'h0000A283, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, r, e);
        cyc(1'b1, 32'h00528333, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, r, e);
        chk("lu_load_out", 32'(e), 32'd1);
        idle(1'b1, r, e);
        chk("lu_bubble_valid", 32'(e), 32'd0);
        chk("lu_bubble_ready", 32'(r), 32'd0);
        idle(1'b1, r, e);
        chk("lu_after_bubble", 32'(e), 32'd1);
        drain();

        // LW x5 then independent ADD x6,x7,x8: no bubble
        cyc(1'b1, 32'h0000A283, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, r, e);
        cyc(1'b1, 32'h00838333, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, r, e);
        idle(1'b1, r, e);
        chk("nolu_back_to_back", 32'(e), 32'd1);
        drain();

        // Branch and jump immediates
        cyc(1'b1, 32'hFE000CE3, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, r, e);
        chk("beq_imm", bus.ex_imm, 32'hFFFF_FFF8);
        cyc(1'b1, 32'h001000EF, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, r, e);
        chk("jal_imm", bus.ex_imm, 32'h0000_0800);
        drain();

        // Flush drops both the held instruction and the one offered
        cyc(1'b1, 32'hFFB00093, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, r, e);
        cyc(1'b1, 32'h001000EF, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r, e);
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        idle(1'b1, r, e);
        chk("flush_no_deliver", 32'(e), 32'd0);
        drain();

        // Asynchronous reset while holding
        cyc(1'b1, 32'hFFB00093, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, r, e);
        reset = 1'b1;
        #1;
        chk("areset_valid", 32'(bus.ex_valid), 32'd0);
        chk("areset_pc",    bus.ex_pc,         32'd0);
        chk("areset_ready", 32'(bus.if_ready), 32'd1);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Randomized traffic with writebacks, backpressure and occasional flushes
        for (int n = 0; n < 1500; n++) begin
            fl = ($urandom_range(0, 99) < 3);
            cyc($urandom_range(0, 99) < 75, rand_instr(), fl,
                fl ? 1'b0 : ($urandom_range(0, 99) < 70),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, r, e);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
